rate_tick_gen: RTL and testbench



---
 rtl/rate_tick_gen.sv | 128 ++++++++++++
 tb/tb_rate_tick_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rate_tick_gen: switch-selected one-cycle enable tick for a display counter|
// | Optional SINGLE_STEP_EN adds a step input for manual ticks while held.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rate_tick_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 28,
  parameter int TCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [1:0]        sel,
  input  logic              enable,
  output logic              tick,
  output logic [1:0]        active_sel,
  output logic [TCNT_W-1:0] tick_count,
  output logic              running
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD_1 = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] RELOAD_2 = CNT_W'(2 * CLK_HZ - 1);
  localparam logic [CNT_W-1:0] RELOAD_4 = CNT_W'(4 * CLK_HZ - 1);

  function automatic logic [CNT_W-1:0] reload_of(input logic [1:0] s);
    case (s)
      2'b00:   reload_of = '0;
      2'b01:   reload_of = RELOAD_1;
      2'b10:   reload_of = RELOAD_2;
      default: reload_of = RELOAD_4;
    endcase
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [TCNT_W-1:0]  tcnt_nxt;
  logic [1:0]         asel_nxt;
  logic               tick_nxt;
  logic               sel_chg;

  assign sel_chg = (sel != active_sel);

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  always_ff @(posedge clock) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign step_rise = step & ~step_q;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tcnt_nxt  = tick_count;
    asel_nxt  = active_sel;
    tick_nxt  = 1'b0;
    case (state)
      S_LOAD: begin
        asel_nxt  = sel;
        count_nxt = reload_of(sel);
        state_nxt = enable ? S_RUN : S_HOLD;
      end
      S_RUN: begin
        // A sampled rate change abandons the partial period without a tick.
        if (sel_chg) begin
          state_nxt = S_LOAD;
        end else if (!enable) begin
          state_nxt = S_HOLD;
        end else if (count == '0) begin
          tick_nxt  = 1'b1;
          count_nxt = reload_of(active_sel);
          tcnt_nxt  = tick_count + 1'b1;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
      S_HOLD: begin
        if (sel_chg) begin
          state_nxt = S_LOAD;
        end else if (enable) begin
          state_nxt = S_RUN;
        end
`ifdef SINGLE_STEP_EN
        else if (step_rise) begin
          tick_nxt  = 1'b1;
          count_nxt = reload_of(active_sel);
          tcnt_nxt  = tick_count + 1'b1;
        end
`endif
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_LOAD;
      count      <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
      active_sel <= 2'b00;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      tick       <= tick_nxt;
      tick_count <= tcnt_nxt;
      active_sel <= asel_nxt;
      running    <= (state_nxt == S_RUN);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rate_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for rate_tick_gen: expected tick cycles are queued per scenario
// and popped as the DUT ticks; timing is counted from the LOAD cycle.
module tb_rate_tick_gen;
  localparam int CLK_HZ = 4;
  localparam int CNT_W  = 8;
  localparam int TCNT_W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [1:0]        sel = 2'b00;
`ifdef SINGLE_STEP_EN
  logic              step = 1'b0;
`endif
  logic              tick;
  logic [1:0]        active_sel;
  logic [TCNT_W-1:0] tick_count;
  logic              running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int exp_q[$];

  rate_tick_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .TCNT_W(TCNT_W)) dut (
    .clock(clock),
    .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .sel(sel),
    .enable(enable),
    .tick(tick),
    .active_sel(active_sel),
    .tick_count(tick_count),
    .running(running)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Leaves the bench at the negedge of cycle 0 (state LOAD, reset released).
  task automatic do_reset(input logic [1:0] s, input logic en);
    @(negedge clock);
    reset = 1'b1; sel = s; enable = en;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    base = cyc;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (tick_count !== '0) begin errors++; $display("FAIL reset_tick_count: got %0d want 0", tick_count); end
    checks++; if (active_sel !== 2'b00) begin errors++; $display("FAIL reset_active_sel: got %b want 00", active_sel); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
  endtask

  task automatic test_basic();
    logic exp_tick;
    do_reset(2'b01, 1'b1);
    exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(13);
    for (int r = 0; r <= 15; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL basic_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
      checks++;
      if (running !== (r >= 1)) begin errors++; $display("FAIL basic_running cycle %0d: got %b want %b", r, running, (r >= 1)); end
    end
    checks++; if (tick_count !== 8'd3) begin errors++; $display("FAIL basic_tick_count: got %0d want 3", tick_count); end
    checks++; if (active_sel !== 2'b01) begin errors++; $display("FAIL basic_active_sel: got %b want 01", active_sel); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing_ticks: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_fast_wrap();
    logic exp_tick;
    do_reset(2'b00, 1'b1);
    for (int i = 2; i <= 257; i++) exp_q.push_back(i);
    for (int r = 0; r <= 257; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL fast_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
      if (r == 256) begin
        checks++; if (tick_count !== 8'd255) begin errors++; $display("FAIL fast_count_255: got %0d want 255", tick_count); end
      end
      if (r == 257) begin
        checks++; if (tick_count !== 8'd0) begin errors++; $display("FAIL fast_count_wrap: got %0d want 0", tick_count); end
      end
    end
  endtask

  task automatic test_pause();
    logic exp_tick;
    logic exp_run;
    do_reset(2'b11, 1'b1);
    // Enable low for cycles 25..31; remaining count of 7 resumes at cycle 33.
    exp_q.push_back(17); exp_q.push_back(41);
    for (int r = 0; r <= 45; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      exp_run = (r >= 1) && !(r >= 26 && r <= 32);
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL pause_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
      checks++;
      if (running !== exp_run) begin errors++; $display("FAIL pause_running cycle %0d: got %b want %b", r, running, exp_run); end
      if (r == 25) enable = 1'b0;
      if (r == 32) enable = 1'b1;
    end
    checks++; if (tick_count !== 8'd2) begin errors++; $display("FAIL pause_tick_count: got %0d want 2", tick_count); end
  endtask

  task automatic test_sel_change();
    logic exp_tick;
    do_reset(2'b10, 1'b1);
    exp_q.push_back(9); exp_q.push_back(19); exp_q.push_back(23);
    for (int r = 0; r <= 24; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL selchg_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
      if (r == 14) begin
        checks++; if (active_sel !== 2'b10) begin errors++; $display("FAIL selchg_load_asel: got %b want 10", active_sel); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL selchg_load_running: got %b want 0", running); end
      end
      if (r == 15) begin
        checks++; if (active_sel !== 2'b01) begin errors++; $display("FAIL selchg_new_asel: got %b want 01", active_sel); end
      end
      if (r == 13) sel = 2'b01;
    end
    checks++; if (tick_count !== 8'd3) begin errors++; $display("FAIL selchg_tick_count: got %0d want 3", tick_count); end
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    do_reset(2'b01, 1'b1);
    exp_q.push_back(5);
    for (int r = 0; r <= 8; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL rstmid_pre_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
    end
    // Cycle 8 has count==0, so a tick would be due next cycle.
    reset = 1'b1;
    @(negedge clock);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick: got %b want 0", tick); end
    checks++; if (tick_count !== '0) begin errors++; $display("FAIL rstmid_tick_count: got %0d want 0", tick_count); end
    checks++; if (active_sel !== 2'b00) begin errors++; $display("FAIL rstmid_active_sel: got %b want 00", active_sel); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rstmid_running: got %b want 0", running); end
    reset = 1'b0;
    base = cyc;
    exp_q.delete();
    exp_q.push_back(5); exp_q.push_back(9);
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL rstmid_post_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    logic exp_tick;
    do_reset(2'b01, 1'b0);
    exp_q.push_back(4);
    for (int r = 0; r <= 8; r++) begin
      if (r > 0) @(negedge clock);
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == r);
      if (exp_tick) void'(exp_q.pop_front());
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL step_tick cycle %0d: got %b want %b", r, tick, exp_tick); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL step_running cycle %0d: got %b want 0", r, running); end
      if (r == 3) step = 1'b1;
      if (r == 6) step = 1'b0;
    end
    checks++; if (tick_count !== 8'd1) begin errors++; $display("FAIL step_tick_count: got %0d want 1", tick_count); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fast_wrap();
    test_pause();
    test_sel_change();
    test_reset_mid();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
